// File: rtl/spi_slave_sync_if.sv
// SPI pin bundle plus the word-level tx/rx handshake of spi_slave_sync.
// The slave modport is the core's view; the master modport is the pad/host side.
interface spi_slave_sync_if #(
  parameter int unsigned DATA_W = 64
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              overrun;
  logic              frame_err;
  logic              busy;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, rx_ready,
    output miso, miso_oe, tx_load, rx_data, rx_valid, overrun, frame_err, busy
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, rx_ready,
    input  miso, miso_oe, tx_load, rx_data, rx_valid, overrun, frame_err, busy
  );
endinterface

// File: rtl/spi_slave_sync.sv
// Oversampled SPI slave: SCLK/CS_n/MOSI are synchronised into clk, so all logic
// runs in the system clock domain. Supports all CPOL/CPHA modes and multi-word frames.
module spi_slave_sync #(
  parameter int unsigned DATA_W      = 64,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_slave_sync_if.slave      bus
);

  localparam int unsigned CNT_W  = $clog2(DATA_W);
  localparam int unsigned WARM_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   w_cs_s;
  logic                   w_sclk_s;
  logic                   w_mosi_s;

  logic [WARM_W-1:0]      r_warm;
  logic                   r_armed;
  logic                   w_warm_done;

  logic                   w_lead;
  logic                   w_trail;
  logic                   w_sample;
  logic                   w_shift;
  logic                   w_start;

  logic                   r_miso;
  logic                   r_miso_oe;
  logic                   r_busy;
  logic                   r_tx_load;
  logic                   r_overrun;
  logic                   r_frame_err;
  logic                   r_rx_valid;
  logic [DATA_W-1:0]      r_rx_data;
  logic [DATA_W-2:0]      r_shreg_in;
  logic [DATA_W-1:0]      r_shreg_out;
  logic [CNT_W-1:0]       r_bit_cnt;

  logic                   w_miso_nxt;
  logic                   w_tx_load_nxt;
  logic                   w_overrun_nxt;
  logic                   w_frame_err_nxt;
  logic                   w_rx_valid_nxt;
  logic [DATA_W-1:0]      w_rx_data_nxt;
  logic [DATA_W-2:0]      w_shreg_in_nxt;
  logic [DATA_W-1:0]      w_shreg_out_nxt;
  logic [CNT_W-1:0]       w_bit_cnt_nxt;
  logic [DATA_W-1:0]      w_word_in;

  // Input synchronisers; sclk resets to its idle level so reset never fakes an edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= {SYNC_STAGES{CPOL}};
      r_mosi_sync <= '0;
      r_sclk_d    <= CPOL;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      r_sclk_d    <= w_sclk_s;
    end
  end

  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  assign w_lead   = (r_sclk_d == CPOL) && (w_sclk_s != CPOL);
  assign w_trail  = (r_sclk_d != CPOL) && (w_sclk_s == CPOL);
  assign w_sample = CPHA ? w_trail : w_lead;
  assign w_shift  = CPHA ? w_lead  : w_trail;

  // A frame may only start after CS has been genuinely seen high; the reset value
  // flushing out of the chain must not look like a CS fall.
  assign w_warm_done = (r_warm == WARM_W'(SYNC_STAGES));
  assign w_start     = (r_state == ST_IDLE) && r_armed && !w_cs_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_warm  <= '0;
      r_armed <= 1'b0;
    end else begin
      if (!w_warm_done) begin
        r_warm <= r_warm + WARM_W'(1);
      end
      if (w_start) begin
        r_armed <= 1'b0;
      end else if (w_warm_done && w_cs_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state; CS rise takes priority over any SCLK edge
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (w_cs_s)  w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_word_in = {r_shreg_in, w_mosi_s};

  // FSM outputs and datapath next values
  always_comb begin
    w_miso_nxt      = r_miso;
    w_tx_load_nxt   = 1'b0;
    w_overrun_nxt   = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_rx_valid_nxt  = r_rx_valid & ~bus.rx_ready;
    w_rx_data_nxt   = r_rx_data;
    w_shreg_in_nxt  = r_shreg_in;
    w_shreg_out_nxt = r_shreg_out;
    w_bit_cnt_nxt   = r_bit_cnt;

    case (r_state)
      ST_IDLE: begin
        w_miso_nxt    = 1'b0;
        w_bit_cnt_nxt = '0;
        if (w_start) begin
          w_tx_load_nxt   = 1'b1;
          w_miso_nxt      = bus.tx_data[DATA_W-1];
          // CPHA=0 has already presented the MSB, so the register holds the rest
          w_shreg_out_nxt = CPHA ? bus.tx_data : {bus.tx_data[DATA_W-2:0], 1'b0};
        end
      end
      ST_ACTIVE: begin
        if (w_cs_s) begin
          w_miso_nxt      = 1'b0;
          w_bit_cnt_nxt   = '0;
          w_frame_err_nxt = (r_bit_cnt != '0);
        end else if (w_sample) begin
          w_shreg_in_nxt = w_word_in[DATA_W-2:0];
          if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
            w_rx_data_nxt   = w_word_in;
            w_rx_valid_nxt  = 1'b1;
            w_overrun_nxt   = r_rx_valid & ~bus.rx_ready;
            w_bit_cnt_nxt   = '0;
            w_shreg_out_nxt = bus.tx_data;
            w_tx_load_nxt   = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          end
        end else if (w_shift) begin
          w_miso_nxt      = r_shreg_out[DATA_W-1];
          w_shreg_out_nxt = {r_shreg_out[DATA_W-2:0], 1'b0};
        end
      end
      default: begin
        w_miso_nxt = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_busy      <= 1'b0;
      r_tx_load   <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= '0;
      r_shreg_in  <= '0;
      r_shreg_out <= '0;
      r_bit_cnt   <= '0;
    end else begin
      r_miso      <= w_miso_nxt;
      r_miso_oe   <= (w_state_nxt == ST_ACTIVE);
      r_busy      <= (w_state_nxt == ST_ACTIVE);
      r_tx_load   <= w_tx_load_nxt;
      r_overrun   <= w_overrun_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_shreg_in  <= w_shreg_in_nxt;
      r_shreg_out <= w_shreg_out_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
    end
  end

  assign bus.miso      = r_miso;
  assign bus.miso_oe   = r_miso_oe;
  assign bus.busy      = r_busy;
  assign bus.tx_load   = r_tx_load;
  assign bus.overrun   = r_overrun;
  assign bus.frame_err = r_frame_err;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.rx_data   = r_rx_data;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: one 64-bit mode-0 instance and four 8-bit
// instances (modes 0..3); a bit-banged SPI master is steered to one of them by sel.
module tb_spi_slave_sync;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk_drv;
  logic        cs_drv;
  logic        mosi_drv;
  logic        rdy;
  logic [63:0] tx64;
  logic [7:0]  tx8;
  logic [2:0]  sel;

  int n_checks = 0;
  int n_fail   = 0;
  int n_load   = 0;
  int n_ovr    = 0;
  int n_ferr   = 0;
  int n_vld    = 0;
  logic prev_vld = 1'b0;

  always #5 clk = ~clk;

  spi_slave_sync_if #(.DATA_W(64)) if64  ();
  spi_slave_sync_if #(.DATA_W(8))  if8_0 ();
  spi_slave_sync_if #(.DATA_W(8))  if8_1 ();
  spi_slave_sync_if #(.DATA_W(8))  if8_2 ();
  spi_slave_sync_if #(.DATA_W(8))  if8_3 ();

  assign if64.cs_n     = (sel == 3'd0) ? cs_drv   : 1'b1;
  assign if64.sclk     = (sel == 3'd0) ? sclk_drv : 1'b0;
  assign if64.mosi     = mosi_drv;
  assign if64.tx_data  = tx64;
  assign if64.rx_ready = rdy;

  assign if8_0.cs_n     = (sel == 3'd1) ? cs_drv   : 1'b1;
  assign if8_0.sclk     = (sel == 3'd1) ? sclk_drv : 1'b0;
  assign if8_0.mosi     = mosi_drv;
  assign if8_0.tx_data  = tx8;
  assign if8_0.rx_ready = rdy;

  assign if8_1.cs_n     = (sel == 3'd2) ? cs_drv   : 1'b1;
  assign if8_1.sclk     = (sel == 3'd2) ? sclk_drv : 1'b0;
  assign if8_1.mosi     = mosi_drv;
  assign if8_1.tx_data  = tx8;
  assign if8_1.rx_ready = rdy;

  assign if8_2.cs_n     = (sel == 3'd3) ? cs_drv   : 1'b1;
  assign if8_2.sclk     = (sel == 3'd3) ? sclk_drv : 1'b1;
  assign if8_2.mosi     = mosi_drv;
  assign if8_2.tx_data  = tx8;
  assign if8_2.rx_ready = rdy;

  assign if8_3.cs_n     = (sel == 3'd4) ? cs_drv   : 1'b1;
  assign if8_3.sclk     = (sel == 3'd4) ? sclk_drv : 1'b1;
  assign if8_3.mosi     = mosi_drv;
  assign if8_3.tx_data  = tx8;
  assign if8_3.rx_ready = rdy;

  spi_slave_sync #(.DATA_W(64), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2))
    u_dut64 (.clk(clk), .rst(rst), .bus(if64));
  spi_slave_sync #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2))
    u_dut_m0 (.clk(clk), .rst(rst), .bus(if8_0));
  spi_slave_sync #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b1), .SYNC_STAGES(2))
    u_dut_m1 (.clk(clk), .rst(rst), .bus(if8_1));
  spi_slave_sync #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b0), .SYNC_STAGES(2))
    u_dut_m2 (.clk(clk), .rst(rst), .bus(if8_2));
  spi_slave_sync #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2))
    u_dut_m3 (.clk(clk), .rst(rst), .bus(if8_3));

  // status = {miso, miso_oe, tx_load, rx_valid, overrun, frame_err, busy}
  logic [6:0]  st0, st1, st2, st3, st4, cur_st;
  logic [63:0] cur_rx;
  assign st0 = {if64.miso,  if64.miso_oe,  if64.tx_load,  if64.rx_valid,  if64.overrun,  if64.frame_err,  if64.busy};
  assign st1 = {if8_0.miso, if8_0.miso_oe, if8_0.tx_load, if8_0.rx_valid, if8_0.overrun, if8_0.frame_err, if8_0.busy};
  assign st2 = {if8_1.miso, if8_1.miso_oe, if8_1.tx_load, if8_1.rx_valid, if8_1.overrun, if8_1.frame_err, if8_1.busy};
  assign st3 = {if8_2.miso, if8_2.miso_oe, if8_2.tx_load, if8_2.rx_valid, if8_2.overrun, if8_2.frame_err, if8_2.busy};
  assign st4 = {if8_3.miso, if8_3.miso_oe, if8_3.tx_load, if8_3.rx_valid, if8_3.overrun, if8_3.frame_err, if8_3.busy};

  always_comb begin
    case (sel)
      3'd1:    begin cur_st = st1; cur_rx = {56'd0, if8_0.rx_data}; end
      3'd2:    begin cur_st = st2; cur_rx = {56'd0, if8_1.rx_data}; end
      3'd3:    begin cur_st = st3; cur_rx = {56'd0, if8_2.rx_data}; end
      3'd4:    begin cur_st = st4; cur_rx = {56'd0, if8_3.rx_data}; end
      default: begin cur_st = st0; cur_rx = if64.rx_data; end
    endcase
  end

  logic cur_miso, cur_oe, cur_load, cur_valid, cur_ovr, cur_ferr, cur_busy;
  assign {cur_miso, cur_oe, cur_load, cur_valid, cur_ovr, cur_ferr, cur_busy} = cur_st;

  // Pulse counters for the selected instance (high cycles; rising edges for rx_valid)
  always @(negedge clk) begin
    if (cur_load) n_load++;
    if (cur_ovr)  n_ovr++;
    if (cur_ferr) n_ferr++;
    if (cur_valid && !prev_vld) n_vld++;
    prev_vld = cur_valid;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_fall();
    cs_drv = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_rise();
    wait_clks(HALF);
    cs_drv = 1'b1;
    wait_clks(2 * HALF);
  endtask

  // Master shifts nbits of mo (MSB first) and samples miso at each sample edge;
  // loads = tx_load count at the moment of the final sample edge.
  task automatic xfer(input int nbits, input bit cpol, input bit cpha,
                      input logic [63:0] mo, output logic [63:0] mi, output int loads);
    mi = '0;
    loads = 0;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!cpha) begin
        mosi_drv = mo[i];
        wait_clks(HALF);
        mi[i] = cur_miso;
        if (i == 0) loads = n_load;
        sclk_drv = ~cpol;
        wait_clks(HALF);
        sclk_drv = cpol;
      end else begin
        sclk_drv = ~cpol;
        mosi_drv = mo[i];
        wait_clks(HALF);
        mi[i] = cur_miso;
        if (i == 0) loads = n_load;
        sclk_drv = cpol;
        wait_clks(HALF);
      end
    end
  endtask

  task automatic consume();
    rdy = 1'b1;
    wait_clks(1);
    rdy = 1'b0;
    wait_clks(1);
  endtask

  task automatic test_reset();
    rst = 1'b0; sel = 3'd0; cs_drv = 1'b1; sclk_drv = 1'b0; mosi_drv = 1'b0;
    rdy = 1'b0; tx64 = '0; tx8 = '0;
    wait_clks(3);
    n_checks++; if (cur_miso  !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b want 0", cur_miso); end
    n_checks++; if (cur_oe    !== 1'b0) begin n_fail++; $display("FAIL reset_miso_oe: got %b want 0", cur_oe); end
    n_checks++; if (cur_load  !== 1'b0) begin n_fail++; $display("FAIL reset_tx_load: got %b want 0", cur_load); end
    n_checks++; if (cur_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", cur_valid); end
    n_checks++; if (cur_ovr   !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", cur_ovr); end
    n_checks++; if (cur_ferr  !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", cur_ferr); end
    n_checks++; if (cur_busy  !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", cur_busy); end
    n_checks++; if (cur_rx    !== 64'd0) begin n_fail++; $display("FAIL reset_rx_data: got %h want 0", cur_rx); end
    rst = 1'b1;
    wait_clks(10);
    n_checks++; if (cur_busy  !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", cur_busy); end
  endtask

  task automatic test_mode0_64();
    logic [63:0] mi;
    int ld, b_load, b_ovr, b_ferr;
    sel = 3'd0; sclk_drv = 1'b0; rdy = 1'b0;
    tx64 = 64'h0123456789ABCDEF;
    wait_clks(4);
    b_load = n_load; b_ovr = n_ovr; b_ferr = n_ferr;
    cs_drv = 1'b0;
    wait_clks(2);
    n_checks++; if (cur_load !== 1'b0) begin n_fail++; $display("FAIL m64_load_early: got %b want 0", cur_load); end
    wait_clks(1);
    n_checks++; if (cur_load !== 1'b1) begin n_fail++; $display("FAIL m64_load_latency: got %b want 1", cur_load); end
    wait_clks(HALF - 3);
    n_checks++; if (cur_busy !== 1'b1) begin n_fail++; $display("FAIL m64_busy: got %b want 1", cur_busy); end
    n_checks++; if (cur_oe   !== 1'b1) begin n_fail++; $display("FAIL m64_miso_oe: got %b want 1", cur_oe); end
    xfer(64, 1'b0, 1'b0, 64'hFEDCBA9876543210, mi, ld);
    cs_rise();
    n_checks++; if (cur_rx !== 64'hFEDCBA9876543210) begin n_fail++; $display("FAIL m64_rx_data: got %h want fedcba9876543210", cur_rx); end
    n_checks++; if (cur_valid !== 1'b1) begin n_fail++; $display("FAIL m64_rx_valid: got %b want 1", cur_valid); end
    n_checks++; if (mi !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL m64_master_rx: got %h want 0123456789abcdef", mi); end
    n_checks++; if (ld - b_load !== 1) begin n_fail++; $display("FAIL m64_tx_loads: got %0d want 1", ld - b_load); end
    n_checks++; if (n_ovr - b_ovr !== 0) begin n_fail++; $display("FAIL m64_overrun: got %0d want 0", n_ovr - b_ovr); end
    n_checks++; if (n_ferr - b_ferr !== 0) begin n_fail++; $display("FAIL m64_frame_err: got %0d want 0", n_ferr - b_ferr); end
    n_checks++; if (cur_busy !== 1'b0) begin n_fail++; $display("FAIL m64_busy_end: got %b want 0", cur_busy); end
    consume();
    n_checks++; if (cur_valid !== 1'b0) begin n_fail++; $display("FAIL m64_consume: got %b want 0", cur_valid); end
  endtask

  task automatic test_modes();
    for (int m = 0; m < 4; m++) begin
      logic [63:0] mi;
      int ld, b_load, b_ferr;
      bit cpol, cpha;
      cpol = m[1]; cpha = m[0];
      sclk_drv = cpol;
      sel = 3'(m + 1);
      rdy = 1'b0; tx8 = 8'hA5;
      wait_clks(4);
      b_load = n_load; b_ferr = n_ferr;
      cs_fall();
      xfer(8, cpol, cpha, 64'h3C, mi, ld);
      cs_rise();
      n_checks++; if (cur_rx !== 64'h3C) begin n_fail++; $display("FAIL mode%0d_rx_data: got %h want 3c", m, cur_rx); end
      n_checks++; if (cur_valid !== 1'b1) begin n_fail++; $display("FAIL mode%0d_rx_valid: got %b want 1", m, cur_valid); end
      n_checks++; if (mi !== 64'hA5) begin n_fail++; $display("FAIL mode%0d_master_rx: got %h want a5", m, mi); end
      n_checks++; if (ld - b_load !== 1) begin n_fail++; $display("FAIL mode%0d_tx_loads: got %0d want 1", m, ld - b_load); end
      n_checks++; if (n_ferr - b_ferr !== 0) begin n_fail++; $display("FAIL mode%0d_frame_err: got %0d want 0", m, n_ferr - b_ferr); end
      consume();
      n_checks++; if (cur_valid !== 1'b0) begin n_fail++; $display("FAIL mode%0d_consume: got %b want 0", m, cur_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] mi1, mi2;
    int ld1, ld2, b_load, b_vld, b_ovr;
    sclk_drv = 1'b0; sel = 3'd1; rdy = 1'b1; tx8 = 8'h55;
    wait_clks(4);
    b_load = n_load; b_vld = n_vld; b_ovr = n_ovr;
    cs_fall();
    tx8 = 8'hAA;
    xfer(8, 1'b0, 1'b0, 64'h11, mi1, ld1);
    n_checks++; if (cur_rx !== 64'h11) begin n_fail++; $display("FAIL b2b_rx_word1: got %h want 11", cur_rx); end
    xfer(8, 1'b0, 1'b0, 64'h22, mi2, ld2);
    cs_rise();
    n_checks++; if (cur_rx !== 64'h22) begin n_fail++; $display("FAIL b2b_rx_word2: got %h want 22", cur_rx); end
    n_checks++; if (mi1 !== 64'h55) begin n_fail++; $display("FAIL b2b_master_word1: got %h want 55", mi1); end
    n_checks++; if (mi2 !== 64'hAA) begin n_fail++; $display("FAIL b2b_master_word2: got %h want aa", mi2); end
    n_checks++; if (ld2 - b_load !== 2) begin n_fail++; $display("FAIL b2b_tx_loads: got %0d want 2", ld2 - b_load); end
    n_checks++; if (n_vld - b_vld !== 2) begin n_fail++; $display("FAIL b2b_rx_valid_updates: got %0d want 2", n_vld - b_vld); end
    n_checks++; if (n_ovr - b_ovr !== 0) begin n_fail++; $display("FAIL b2b_overrun: got %0d want 0", n_ovr - b_ovr); end
    rdy = 1'b0;
    wait_clks(2);
  endtask

  task automatic test_overrun();
    logic [63:0] mi;
    int ld, b_ovr;
    sel = 3'd1; rdy = 1'b0; tx8 = 8'h00;
    wait_clks(4);
    b_ovr = n_ovr;
    cs_fall();
    xfer(8, 1'b0, 1'b0, 64'h5A, mi, ld);
    xfer(8, 1'b0, 1'b0, 64'hC3, mi, ld);
    cs_rise();
    n_checks++; if (n_ovr - b_ovr !== 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d want 1", n_ovr - b_ovr); end
    n_checks++; if (cur_rx !== 64'hC3) begin n_fail++; $display("FAIL ovr_rx_data: got %h want c3", cur_rx); end
    wait_clks(10);
    n_checks++; if (cur_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_held: got %b want 1", cur_valid); end
    consume();
    n_checks++; if (cur_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_consume: got %b want 0", cur_valid); end
  endtask

  task automatic test_frame_err();
    logic [63:0] mi;
    int ld, b_ferr, b_ovr;
    sel = 3'd1; rdy = 1'b0; tx8 = 8'h0F;
    wait_clks(4);
    cs_fall();
    xfer(8, 1'b0, 1'b0, 64'h96, mi, ld);
    cs_rise();
    b_ferr = n_ferr; b_ovr = n_ovr;
    tx8 = 8'hFF;
    cs_fall();
    xfer(5, 1'b0, 1'b0, 64'h1F, mi, ld);
    cs_rise();
    n_checks++; if (n_ferr - b_ferr !== 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d want 1", n_ferr - b_ferr); end
    n_checks++; if (n_ovr - b_ovr !== 0) begin n_fail++; $display("FAIL ferr_overrun: got %0d want 0", n_ovr - b_ovr); end
    n_checks++; if (cur_valid !== 1'b1) begin n_fail++; $display("FAIL ferr_rx_valid: got %b want 1", cur_valid); end
    n_checks++; if (cur_rx !== 64'h96) begin n_fail++; $display("FAIL ferr_rx_data: got %h want 96", cur_rx); end
    n_checks++; if (cur_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy: got %b want 0", cur_busy); end
    n_checks++; if (cur_miso !== 1'b0) begin n_fail++; $display("FAIL ferr_miso: got %b want 0", cur_miso); end
    n_checks++; if (cur_oe !== 1'b0) begin n_fail++; $display("FAIL ferr_miso_oe: got %b want 0", cur_oe); end
    consume();
    tx8 = 8'h69;
    cs_fall();
    xfer(8, 1'b0, 1'b0, 64'h4B, mi, ld);
    cs_rise();
    n_checks++; if (cur_rx !== 64'h4B) begin n_fail++; $display("FAIL ferr_next_rx: got %h want 4b", cur_rx); end
    n_checks++; if (mi !== 64'h69) begin n_fail++; $display("FAIL ferr_next_master: got %h want 69", mi); end
    n_checks++; if (cur_valid !== 1'b1) begin n_fail++; $display("FAIL ferr_next_valid: got %b want 1", cur_valid); end
    consume();
  endtask

  task automatic test_reset_midframe();
    logic [63:0] mi;
    int ld, b_load;
    sel = 3'd0; sclk_drv = 1'b0; rdy = 1'b0;
    tx64 = 64'hDEADBEEFCAFEF00D;
    wait_clks(4);
    cs_fall();
    xfer(30, 1'b0, 1'b0, 64'h2AAAAAAA, mi, ld);
    rst = 1'b0;
    #1;
    n_checks++; if (cur_busy  !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", cur_busy); end
    n_checks++; if (cur_oe    !== 1'b0) begin n_fail++; $display("FAIL rstmid_miso_oe: got %b want 0", cur_oe); end
    n_checks++; if (cur_miso  !== 1'b0) begin n_fail++; $display("FAIL rstmid_miso: got %b want 0", cur_miso); end
    n_checks++; if (cur_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rx_valid: got %b want 0", cur_valid); end
    n_checks++; if (cur_rx    !== 64'd0) begin n_fail++; $display("FAIL rstmid_rx_data: got %h want 0", cur_rx); end
    wait_clks(4);
    rst = 1'b1;
    b_load = n_load;
    wait_clks(20);
    n_checks++; if (cur_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_start: got %b want 0", cur_busy); end
    n_checks++; if (n_load - b_load !== 0) begin n_fail++; $display("FAIL rstmid_no_load: got %0d want 0", n_load - b_load); end
    cs_drv = 1'b1;
    tx64 = 64'h1122334455667788;
    wait_clks(HALF);
    cs_fall();
    xfer(64, 1'b0, 1'b0, 64'h8000000000000001, mi, ld);
    cs_rise();
    n_checks++; if (cur_rx !== 64'h8000000000000001) begin n_fail++; $display("FAIL rstmid_next_rx: got %h want 8000000000000001", cur_rx); end
    n_checks++; if (mi !== 64'h1122334455667788) begin n_fail++; $display("FAIL rstmid_next_master: got %h want 1122334455667788", mi); end
    n_checks++; if (cur_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_next_valid: got %b want 1", cur_valid); end
  endtask

  initial begin
    test_reset();
    test_mode0_64();
    test_modes();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
